// File: rtl/seq_word_assembler_if.sv
// Serial-bit / assembled-word bus for seq_word_assembler.
// Carries parity_err only when PARITY_CHECK_EN is defined.
interface seq_word_assembler_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 3
);
  localparam int unsigned BCW = $clog2(WIDTH) + 1;

  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CNT_W-1:0] word_count;
  logic             overflow;
  logic [BCW-1:0]   bit_cnt;
`ifdef PARITY_CHECK_EN
  logic             parity_err;
`endif

  modport slave (
    input  bit_in, bit_valid, word_ready,
`ifdef PARITY_CHECK_EN
    output parity_err,
`endif
    output word_out, word_valid, word_count, overflow, bit_cnt
  );

  modport master (
    output bit_in, bit_valid, word_ready,
`ifdef PARITY_CHECK_EN
    input  parity_err,
`endif
    input  word_out, word_valid, word_count, overflow, bit_cnt
  );
endinterface

// File: rtl/seq_word_assembler.sv
// Serial-to-parallel word assembler (MSB first) with a one-entry valid/ready output buffer.
// Optional PARITY_CHECK_EN: each frame carries a trailing even-parity bit; bad frames are dropped and flagged.
module seq_word_assembler #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 3
) (
  input logic                clk,
  input logic                rst,
  seq_word_assembler_if.slave bus
);
  localparam int unsigned BCW = $clog2(WIDTH) + 1;
`ifdef PARITY_CHECK_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  // The shift register only keeps the bits still needed once the frame's last bit arrives.
  localparam int unsigned SW = FRAME - 1;

  typedef enum logic {EMPTY, FULL} buf_state_t;

  buf_state_t       buf_st;
  logic [SW-1:0]    shreg;
  logic [WIDTH-1:0] word_q;
  logic             word_valid_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [BCW-1:0]   bit_cnt_q;
`ifdef PARITY_CHECK_EN
  logic             parity_err_q;
`endif

  logic [FRAME-1:0] shifted;
  logic [WIDTH-1:0] next_word;
  logic             last_bit;
  logic             drain;
  logic             word_ok;

  always_comb begin
    shifted  = {shreg, bus.bit_in};
    last_bit = bus.bit_valid && (bit_cnt_q == BCW'(FRAME - 1));
    drain    = (buf_st == FULL) && bus.word_ready;
`ifdef PARITY_CHECK_EN
    next_word = shreg;
    word_ok   = ~^shifted;
`else
    next_word = shifted;
    word_ok   = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_st       <= EMPTY;
      shreg        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      bit_cnt_q    <= '0;
`ifdef PARITY_CHECK_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (bus.bit_valid) begin
        shreg     <= shifted[SW-1:0];
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BCW'(1);
      end

      if (drain) begin
        buf_st       <= EMPTY;
        word_valid_q <= 1'b0;
        count_q      <= count_q + CNT_W'(1);
      end

      // A load on a draining edge overrides the EMPTY transition above.
      if (last_bit && word_ok) begin
        if (buf_st == EMPTY || drain) begin
          buf_st       <= FULL;
          word_valid_q <= 1'b1;
          word_q       <= next_word;
        end else begin
          ovf_q <= 1'b1;
        end
      end

`ifdef PARITY_CHECK_EN
      parity_err_q <= last_bit && !word_ok;
`endif
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_count = count_q;
  assign bus.overflow   = ovf_q;
  assign bus.bit_cnt    = bit_cnt_q;
`ifdef PARITY_CHECK_EN
  assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_seq_word_assembler.sv
// Self-checking bench for seq_word_assembler: directed sequences, a vector table and
// randomized traffic compared against a frame-level reference model.
module tb_seq_word_assembler;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 3;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FRAME = WIDTH;
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_word_assembler_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_word_assembler #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: bits of the current frame in a queue, plus the buffer contents.
  int          m_frame[$];
  logic [15:0] m_word = '0;
  bit          m_valid = 0;
  int          m_count = 0;
  bit          m_ovf = 0;
  bit          m_perr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit bv, input bit b, input bit rdy);
    logic [15:0] w;
    bit ok;
    if (r) begin
      m_frame.delete();
      m_word = '0; m_valid = 0; m_count = 0; m_ovf = 0; m_perr = 0;
      return;
    end
    m_perr = 0;
    if (m_valid && rdy) begin
      m_valid = 0;
      m_count = (m_count + 1) % (1 << CNT_W);
    end
    if (bv) begin
      m_frame.push_back(int'(b));
      if (m_frame.size() == FRAME) begin
        w = '0;
        for (int i = 0; i < 16; i++) w = {w[14:0], m_frame[i] != 0};
        ok = 1;
        if (PAR) ok = (($countones(w) % 2) == m_frame[FRAME-1]);
        m_perr = !ok;
        if (ok) begin
          if (!m_valid) begin m_word = w; m_valid = 1; end
          else m_ovf = 1;
        end
        m_frame.delete();
      end
    end
  endtask

  task automatic tick();
    model_step(rst, bus.bit_valid, bus.bit_in, bus.word_ready);
    @(posedge clk);
    #1;
    chk("word_valid", 32'(bus.word_valid), 32'(m_valid));
    chk("word_out",   32'(bus.word_out),   32'(m_word));
    chk("word_count", 32'(bus.word_count), 32'(m_count));
    chk("overflow",   32'(bus.overflow),   32'(m_ovf));
    chk("bit_cnt",    32'(bus.bit_cnt),    32'(m_frame.size()));
`ifdef PARITY_CHECK_EN
    chk("parity_err", 32'(bus.parity_err), 32'(m_perr));
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.word_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Sends one frame MSB first; gap idle cycles between bits; rdy_last applies on the final frame bit.
  task automatic send_word(input logic [15:0] w, input bit rdy, input bit rdy_last,
                           input int gap, input bit flip);
    for (int i = 15; i >= 0; i--) begin
      bus.bit_valid = 1'b1; bus.bit_in = w[i];
      bus.word_ready = (i == 0 && !PAR) ? rdy_last : rdy;
      tick();
      if (gap > 0 && i > 0) begin
        bus.bit_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    if (PAR) begin
      bus.bit_valid = 1'b1; bus.bit_in = (^w) ^ flip; bus.word_ready = rdy_last;
      tick();
    end
    bus.bit_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] word;
    int          exp_count;
  } vec_t;
  vec_t vecs[9];

  initial begin
    bus.bit_valid = 1'b0; bus.bit_in = 1'b0; bus.word_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst word_valid", 32'(bus.word_valid), 0);
    chk("rst word_out",   32'(bus.word_out),   0);
    chk("rst word_count", 32'(bus.word_count), 0);
    chk("rst overflow",   32'(bus.overflow),   0);
    chk("rst bit_cnt",    32'(bus.bit_cnt),    0);

    // Basic word: valid for exactly one cycle with ready held high
    send_word(16'hBBCB, 1, 1, 0, 0);
    chk("basic valid", 32'(bus.word_valid), 1);
    chk("basic word",  32'(bus.word_out),   32'h BBCB);
    chk("basic cnt0",  32'(bus.word_count), 0);
    bus.word_ready = 1'b1; tick();
    chk("basic valid drop", 32'(bus.word_valid), 0);
    chk("basic cnt1",       32'(bus.word_count), 1);
    chk("basic ovf",        32'(bus.overflow),   0);

    // Backpressure and overflow
    do_reset();
    send_word(16'hBBCB, 0, 0, 0, 0);
    send_word(16'h1234, 0, 0, 0, 0);
    chk("bp word",  32'(bus.word_out),   32'h BBCB);
    chk("bp valid", 32'(bus.word_valid), 1);
    chk("bp ovf",   32'(bus.overflow),   1);
    bus.word_ready = 1'b1; tick();
    bus.word_ready = 1'b0;
    chk("bp cnt",       32'(bus.word_count), 1);
    chk("bp valid off", 32'(bus.word_valid), 0);
    chk("bp ovf stick", 32'(bus.overflow),   1);

    // Gapped bits, ready held high
    do_reset();
    send_word(16'hA5A5, 1, 1, 1, 0);
    chk("gap word1", 32'(bus.word_out), 32'h A5A5);
    send_word(16'h0F0F, 1, 1, 1, 0);
    chk("gap word2", 32'(bus.word_out), 32'h 0F0F);
    bus.word_ready = 1'b1; tick();
    chk("gap cnt", 32'(bus.word_count), 2);

    // Simultaneous drain and load on the completing edge
    do_reset();
    send_word(16'hA5A5, 0, 0, 0, 0);
    send_word(16'h0F0F, 0, 1, 0, 0);
    chk("dl valid", 32'(bus.word_valid), 1);
    chk("dl word",  32'(bus.word_out),   32'h 0F0F);
    chk("dl cnt",   32'(bus.word_count), 1);
    chk("dl ovf",   32'(bus.overflow),   0);

    // Reset mid-frame discards stale bits
    do_reset();
    bus.word_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.bit_valid = 1'b1; bus.bit_in = 1'b0; tick();
    end
    chk("mid bit_cnt 9", 32'(bus.bit_cnt), 9);
    do_reset();
    chk("mid bit_cnt 0", 32'(bus.bit_cnt), 0);
    send_word(16'hFFFF, 1, 1, 0, 0);
    chk("mid word", 32'(bus.word_out), 32'h FFFF);

    // Counter wrap table
    vecs = '{'{16'h0001, 1}, '{16'h8000, 2}, '{16'h5A5A, 3}, '{16'hFFFF, 4}, '{16'h0000, 5},
             '{16'hC3C3, 6}, '{16'h1234, 7}, '{16'hBEEF, 0}, '{16'h7FFE, 1}};
    do_reset();
    for (int v = 0; v < 9; v++) begin
      send_word(vecs[v].word, 1, 1, 0, 0);
      chk("wrap word", 32'(bus.word_out), 32'(vecs[v].word));
      bus.word_ready = 1'b1; tick();
      chk("wrap cnt", 32'(bus.word_count), 32'(vecs[v].exp_count));
    end

`ifdef PARITY_CHECK_EN
    do_reset();
    send_word(16'hBBCB, 1, 1, 0, 0);
    chk("par ok word",  32'(bus.word_out),   32'h BBCB);
    chk("par ok valid", 32'(bus.word_valid), 1);
    send_word(16'hBBCB, 1, 1, 0, 1);
    chk("par err pulse", 32'(bus.parity_err), 1);
    chk("par err valid", 32'(bus.word_valid), 0);
    chk("par err cnt",   32'(bus.word_count), 1);
    bus.word_ready = 1'b1; tick();
    chk("par err clear", 32'(bus.parity_err), 0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.bit_valid  = ($urandom_range(0, 3) != 0);
      bus.bit_in     = 1'($urandom);
      bus.word_ready = 1'($urandom);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
